tdc_fine_encoder_pipe: RTL and testbench
========================================

# tdc_fine_encoder_pipe

Parametrised, pipelined thermometer-to-binary fine-phase encoder for the ETROC TDC (TOA and TOT paths). It takes the N-bit thermometer word captured by the delay-line sample DFFs and applies run-time-selectable bubble tolerance. It produces a binary fine code plus per-word error status, with a valid qualifier and fixed latency. Saturating bubble and failure counters are provided for slow-control readback.

## Interface
- N_TAPS, 21, thermometer width; legal range 4..127
- OUT_W, $clog2(N_TAPS+1), binary output width; 5 for N_TAPS=21
- CNT_W, 16, width of each error counter
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears pipeline valids, outputs and counters
- din_valid  in  1  din/level qualify this cycle
- din  in  N_TAPS  thermometer code, LSB-first; bit 0 is the earliest tap
- level  in  2  bubble tolerance L; 1..3; 0 is treated as 1
- cnt_clr  in  1  synchronous clear of both counters
- dout_valid  out  1  bin_out/err valid
- bin_out  out  OUT_W  encoded fine code
- err  out  2  00 clean; 01 bubble corrected; 10 no valid edge; 11 never driven
- cnt_bubble  out  CNT_W  saturating count of err=01 words
- cnt_fail  out  CNT_W  saturating count of err=10 words

## Operation
- Extended vector x[k]: for k<0, x[k]=1; for 0≤k<N, x[k]=din[k]; for k≥N, x[k]=0.
- Raw transition at boundary k (0..N): x[k-1]=1 and x[k]=0. At least one always exists.
- Valid edge at k: x[k-L..k-1] are all 1 and x[k..k+L-1] are all 0, with L being the effective level.
- Encoding rules:
  - Exactly one raw transition: bin_out = that k, err=00.
  - More than one raw transition and at least one valid edge: bin_out = smallest valid k, err=01.
  - No valid edge: bin_out = smallest raw transition k, err=10.
- Pipeline stages:
  - S1: register din, din_valid and effective L as one word. level may change every word.
  - S2: compute raw-transition vector, valid-edge vector, and raw count ≥2 flag.
  - S3: priority-encode, form err, register outputs.
- Counters update on a dout_valid cycle:
  - err=01 increments cnt_bubble.
  - err=10 increments cnt_fail.
  - Both saturate at 2^CNT_W−1 with no wrap.
  - cnt_clr has priority: if asserted in the same cycle as an error word, the counter becomes 0 and that word is not counted.
- Words with din_valid=0 do not advance counters. Their outputs hold: bin_out/err keep their last value and dout_valid=0.

## Timing
- Latency is 3 cycles: din_valid high at edge t gives dout_valid high after edge t+3.
- Throughput is one word per cycle, no back-pressure, no bubbles inserted.
- Counters reflect a word one cycle after its dout_valid, at edge t+4.
- Reset values: dout_valid=0, bin_out=0, err=00, cnt_bubble=0, cnt_fail=0. All S1/S2 valids are 0.
- Reset mid-stream discards in-flight words: no dout_valid for words accepted in the 3 cycles before reset. The first word accepted after reset deasserts emerges 3 cycles later.
- cnt_clr takes effect at the next edge. Reset takes priority over cnt_clr.

## Test plan
- Clean codes, L=2, back-to-back words 0x0000FF, 0x000000, 0x1FFFFF:
  - Outputs bin_out 8, 0, 21, all with err=00.
  - dout_valid is high for exactly three consecutive cycles, starting 3 cycles after the first input.
- Bubble, din=0x0000F7:
  - L=2: bin_out=8, err=01.
  - L=1: bin_out=3, err=01.
  - level=0: identical to L=1.
  - cnt_bubble increments once per word.
- Unresolvable, din=0x155555, L=2:
  - bin_out=1, err=10.
  - cnt_fail increments by 1; cnt_bubble is unchanged.
- Saturation, CNT_W=4:
  - Send 20 consecutive 0x0000F7 words: cnt_bubble ends at 15 and does not wrap.
  - Send one more, with cnt_clr asserted on its dout_valid cycle: cnt_bubble=0.
- Reset mid-stream:
  - Stream 5 valid words and assert reset for 1 cycle after the 3rd is accepted: dout_valid never rises for words 2–3.
  - All outputs and counters read 0 after reset.
  - The next word emerges with 3-cycle latency.
- Gapped input:
  - Alternate din_valid 1/0: dout_valid mirrors the pattern delayed by 3 cycles.
  - bin_out holds its value during gaps and counters are unchanged.

Source files
------------

// File: rtl/tdc_fine_encoder_pipe.sv
// Pipelined thermometer-to-binary fine encoder with bubble tolerance.
// Error words are tallied in saturating counters for slow-control readback.
module tdc_fine_encoder_pipe #(
  parameter int N_TAPS = 21,
  parameter int OUT_W  = $clog2(N_TAPS + 1),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [N_TAPS-1:0] din,
  input  logic [1:0]        level,
  input  logic              cnt_clr,
  output logic              dout_valid,
  output logic [OUT_W-1:0]  bin_out,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  cnt_bubble,
  output logic [CNT_W-1:0]  cnt_fail
);

  localparam int NB = N_TAPS + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic              vld;
    logic [N_TAPS-1:0] din;
    logic [1:0]        lvl;
  } s1_t;

  typedef struct packed {
    logic          vld;
    logic [NB-1:0] raw;
    logic [NB-1:0] edg;
    logic          multi;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic [OUT_W-1:0] raw_idx;
    logic [OUT_W-1:0] edg_idx;
    logic             multi;
    logic             any_edg;
  } s3_t;

  s1_t s1;
  s2_t s2;
  s3_t s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1.vld <= 1'b0;
    end else begin
      s1.vld <= din_valid;
      if (din_valid) begin
        s1.din <= din;
        s1.lvl <= (level == 2'd0) ? 2'd1 : level;
      end
    end
  end

  // Padded vector: three forced 1s below tap 0, three forced 0s above.
  logic [N_TAPS+5:0] xe;
  assign xe = {3'b000, s1.din, 3'b111};

  logic [NB-1:0] raw_c;
  logic [NB-1:0] edg_c;
  logic          multi_c;
  logic          r1, e2, e3;

  always_comb begin
    raw_c = '0;
    edg_c = '0;
    r1    = 1'b0;
    e2    = 1'b0;
    e3    = 1'b0;
    for (int k = 0; k < NB; k++) begin
      r1 = xe[k+2] & ~xe[k+3];
      e2 = xe[k+1] & r1 & ~xe[k+4];
      e3 = xe[k] & e2 & ~xe[k+5];
      raw_c[k] = r1;
      case (s1.lvl)
        2'd2:    edg_c[k] = e2;
        2'd3:    edg_c[k] = e3;
        default: edg_c[k] = r1;
      endcase
    end
    multi_c = |(raw_c & (raw_c - NB'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2.vld <= 1'b0;
    end else begin
      s2.vld <= s1.vld;
      if (s1.vld) begin
        s2.raw   <= raw_c;
        s2.edg   <= edg_c;
        s2.multi <= multi_c;
      end
    end
  end

  logic [OUT_W-1:0] raw_idx_c;
  logic [OUT_W-1:0] edg_idx_c;

  always_comb begin
    raw_idx_c = '0;
    edg_idx_c = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (s2.raw[k]) raw_idx_c = OUT_W'(k);
      if (s2.edg[k]) edg_idx_c = OUT_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3.vld <= 1'b0;
    end else begin
      s3.vld <= s2.vld;
      if (s2.vld) begin
        s3.raw_idx <= raw_idx_c;
        s3.edg_idx <= edg_idx_c;
        s3.multi   <= s2.multi;
        s3.any_edg <= |s2.edg;
      end
    end
  end

  logic [OUT_W-1:0] bin_c;
  logic [1:0]       err_c;

  always_comb begin
    bin_c = s3.raw_idx;
    err_c = 2'b00;
    unique case (1'b1)
      !s3.multi: begin
        bin_c = s3.raw_idx;
        err_c = 2'b00;
      end
      s3.multi && s3.any_edg: begin
        bin_c = s3.edg_idx;
        err_c = 2'b01;
      end
      default: begin
        bin_c = s3.raw_idx;
        err_c = 2'b10;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= 1'b0;
      bin_out    <= '0;
      err        <= 2'b00;
    end else begin
      dout_valid <= s3.vld;
      if (s3.vld) begin
        bin_out <= bin_c;
        err     <= err_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_bubble <= '0;
      cnt_fail   <= '0;
    end else if (dout_valid) begin
      if (err == 2'b01 && cnt_bubble != CMAX)
        cnt_bubble <= cnt_bubble + 1'b1;
      if (err == 2'b10 && cnt_fail != CMAX)
        cnt_fail <= cnt_fail + 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_fine_encoder_pipe.sv
// Bench for tdc_fine_encoder_pipe: vector table, corner sequences,
// and random traffic against a rule-level reference model.
module tb_tdc_fine_encoder_pipe;

  localparam int N  = 21;
  localparam int OW = 5;
  localparam int CW = 4;
  localparam int CM = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          din_valid;
  logic [N-1:0]  din;
  logic [1:0]    level;
  logic          cnt_clr;
  logic          dout_valid;
  logic [OW-1:0] bin_out;
  logic [1:0]    err;
  logic [CW-1:0] cnt_bubble;
  logic [CW-1:0] cnt_fail;

  always #5 clk = ~clk;

  tdc_fine_encoder_pipe #(
    .N_TAPS(N),
    .OUT_W (OW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .level     (level),
    .cnt_clr   (cnt_clr),
    .dout_valid(dout_valid),
    .bin_out   (bin_out),
    .err       (err),
    .cnt_bubble(cnt_bubble),
    .cnt_fail  (cnt_fail)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit v;
    int b;
    int e;
  } ent_t;

  ent_t hist[3];
  int   exp_v, exp_b, exp_e, exp_cb, exp_cf;

  typedef struct {
    logic [N-1:0] d;
    logic [1:0]   l;
    int           b;
    int           e;
  } vec_t;

  vec_t tbl[10];

  function automatic int xbit(input logic [N-1:0] d, input int k);
    if (k < 0) return 1;
    if (k >= N) return 0;
    return int'(d[k]);
  endfunction

  function automatic void ref_enc(input logic [N-1:0] d,
                                  input logic [1:0] lv,
                                  output int b, output int e);
    int L;
    int nraw;
    int fr;
    int fv;
    bit ok;
    L    = (lv == 2'd0) ? 1 : int'(lv);
    nraw = 0;
    fr   = -1;
    fv   = -1;
    for (int k = 0; k <= N; k++) begin
      if (xbit(d, k - 1) == 1 && xbit(d, k) == 0) begin
        nraw++;
        if (fr < 0) fr = k;
        ok = 1'b1;
        for (int j = 1; j <= L; j++)
          if (xbit(d, k - j) != 1 || xbit(d, k + j - 1) != 0) ok = 1'b0;
        if (ok && fv < 0) fv = k;
      end
    end
    if (nraw == 1) begin
      b = fr; e = 0;
    end else if (fv >= 0) begin
      b = fv; e = 1;
    end else begin
      b = fr; e = 2;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_edge();
    int b, e;
    if (reset || cnt_clr) begin
      exp_cb = 0;
      exp_cf = 0;
    end else if (exp_v != 0) begin
      if (exp_e == 1 && exp_cb < CM) exp_cb++;
      if (exp_e == 2 && exp_cf < CM) exp_cf++;
    end
    if (reset) begin
      exp_v = 0; exp_b = 0; exp_e = 0;
      for (int i = 0; i < 3; i++) hist[i].v = 1'b0;
    end else begin
      exp_v = int'(hist[2].v);
      if (hist[2].v) begin
        exp_b = hist[2].b;
        exp_e = hist[2].e;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].v = din_valid;
      if (din_valid) begin
        ref_enc(din, level, b, e);
        hist[0].b = b;
        hist[0].e = e;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_dout_valid", int'(dout_valid), exp_v);
    chk("model_bin_out", int'(bin_out), exp_b);
    chk("model_err", int'(err), exp_e);
    chk("model_cnt_bubble", int'(cnt_bubble), exp_cb);
    chk("model_cnt_fail", int'(cnt_fail), exp_cf);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [N-1:0] d, input logic [1:0] l);
    din_valid = 1'b1;
    din       = d;
    level     = l;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  function automatic logic [N-1:0] gen_word();
    logic [N-1:0] d;
    int k;
    d = '0;
    k = $urandom_range(0, N);
    for (int j = 0; j < k; j++) d[j] = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      for (int j = 0; j < $urandom_range(1, 3); j++)
        d[$urandom_range(0, N - 1)] ^= 1'b1;
    end
    return d;
  endfunction

  initial begin
    int nb, nf, dvq[5], bq[5];
    logic [N-1:0] w;
    reset = 1'b1; din_valid = 1'b0; din = '0; level = 2'd2; cnt_clr = 1'b0;
    exp_v = 0; exp_b = 0; exp_e = 0; exp_cb = 0; exp_cf = 0;
    for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, b: 0, e: 0};
    tick();
    tick();
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_cnt_bubble", int'(cnt_bubble), 0);
    chk("reset_cnt_fail", int'(cnt_fail), 0);
    reset = 1'b0;
    idle(2);

    din_valid = 1'b1; level = 2'd2;
    din = 21'h0000FF; tick();
    din = 21'h000000; tick();
    din = 21'h1FFFFF; tick();
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      dvq[i] = int'(dout_valid);
      bq[i]  = int'(bin_out);
      if (i < 3) chk("clean_err", int'(err), 0);
    end
    chk("clean_dv0", dvq[0], 1);
    chk("clean_dv1", dvq[1], 1);
    chk("clean_dv2", dvq[2], 1);
    chk("clean_dv3", dvq[3], 0);
    chk("clean_dv4", dvq[4], 0);
    chk("clean_bin0", bq[0], 8);
    chk("clean_bin1", bq[1], 0);
    chk("clean_bin2", bq[2], 21);

    tbl[0] = '{d: 21'h0000F7, l: 2'd2, b: 8,  e: 1};
    tbl[1] = '{d: 21'h0000F7, l: 2'd1, b: 3,  e: 1};
    tbl[2] = '{d: 21'h0000F7, l: 2'd0, b: 3,  e: 1};
    tbl[3] = '{d: 21'h155555, l: 2'd2, b: 1,  e: 2};
    tbl[4] = '{d: 21'h0000FF, l: 2'd3, b: 8,  e: 0};
    tbl[5] = '{d: 21'h00000E, l: 2'd1, b: 0,  e: 1};
    tbl[6] = '{d: 21'h00000E, l: 2'd2, b: 4,  e: 1};
    tbl[7] = '{d: 21'h00000E, l: 2'd3, b: 4,  e: 1};
    tbl[8] = '{d: 21'h1FFFFF, l: 2'd3, b: 21, e: 0};
    tbl[9] = '{d: 21'h000001, l: 2'd1, b: 1,  e: 0};
    clr_pulse();
    nb = 0; nf = 0;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].d, tbl[i].l);
      idle(3);
      chk("tbl_dout_valid", int'(dout_valid), 1);
      chk("tbl_bin_out", int'(bin_out), tbl[i].b);
      chk("tbl_err", int'(err), tbl[i].e);
      idle(1);
      if (tbl[i].e == 1) nb++;
      if (tbl[i].e == 2) nf++;
      chk("tbl_cnt_bubble", int'(cnt_bubble), nb);
      chk("tbl_cnt_fail", int'(cnt_fail), nf);
    end

    clr_pulse();
    din_valid = 1'b1; din = 21'h0000F7; level = 2'd2;
    repeat (20) tick();
    idle(5);
    chk("sat_cnt_bubble", int'(cnt_bubble), 15);
    send(21'h0000F7, 2'd2);
    idle(3);
    chk("sat_last_dv", int'(dout_valid), 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sat_clr_cnt", int'(cnt_bubble), 0);
    idle(2);
    chk("sat_clr_hold", int'(cnt_bubble), 0);

    send(21'h155555, 2'd2);
    idle(5);
    chk("pre_rst_cnt_fail", int'(cnt_fail), 1);
    din_valid = 1'b1; level = 2'd2;
    din = 21'h0000F7; tick();
    din = 21'h00003F; tick();
    din = 21'h155555; tick();
    din = 21'h0000F7; reset = 1'b1; tick();
    reset = 1'b0;
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cnt_bubble", int'(cnt_bubble), 0);
    chk("rst_cnt_fail", int'(cnt_fail), 0);
    send(21'h0000FF, 2'd1);
    tick();
    chk("rst_lat_dv1", int'(dout_valid), 0);
    tick();
    chk("rst_lat_dv2", int'(dout_valid), 0);
    tick();
    chk("rst_lat_dv3", int'(dout_valid), 1);
    chk("rst_lat_bin", int'(bin_out), 8);
    idle(3);

    clr_pulse();
    for (int i = 0; i < 12; i++) begin
      din_valid = (i % 2 == 0);
      din = gen_word();
      level = 2'($urandom_range(0, 3));
      tick();
    end
    idle(4);

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      din_valid = ($urandom_range(0, 3) != 0);
      level     = 2'($urandom_range(0, 3));
      w         = gen_word();
      din       = w;
      tick();
    end
    reset = 1'b0; cnt_clr = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
